// File: rtl/dsp48a1_mac_sequencer.sv
// Sequencer driving a single DSP48A1 slice as a signed multiply-accumulate engine.
// It clears the slice, streams operand pairs into it, drains the pipeline, then returns P.
module dsp48a1_mac_sequencer #(
    parameter int LEN_W   = 8,
    parameter int DSP_LAT = 3
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    output logic                     busy,
    input  logic signed [17:0]       in_a,
    input  logic signed [17:0]       in_b,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [47:0]       result,
    output logic                     result_valid,
    output logic signed [17:0]       dsp_a,
    output logic signed [17:0]       dsp_b,
    output logic [7:0]               dsp_opmode,
    output logic                     dsp_ce,
    output logic                     dsp_rst,
    input  logic signed [47:0]       dsp_p
);

    typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, CAPTURE} state_t;

    localparam int              DRN_W    = 3;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DSP_LAT - 2);
    localparam logic [7:0]      OPM_MAC  = 8'b0000_1001;

    state_t                 state_q, state_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       count_q, count_d;
    logic [DRN_W-1:0]       drain_q, drain_d;
    logic                   cap_pend_q, cap_pend_d;
    logic                   busy_q, busy_d;
    logic signed [47:0]     result_q, result_d;
    logic                   result_valid_q, result_valid_d;
    logic signed [17:0]     dsp_a_q, dsp_a_d;
    logic signed [17:0]     dsp_b_q, dsp_b_d;
    logic [7:0]             dsp_opmode_q, dsp_opmode_d;
    logic                   dsp_ce_q, dsp_ce_d;
    logic                   dsp_rst_q, dsp_rst_d;
    logic                   hs;

    assign in_ready     = (state_q == FEED);
    assign hs           = in_ready && in_valid;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign dsp_a        = dsp_a_q;
    assign dsp_b        = dsp_b_q;
    assign dsp_opmode   = dsp_opmode_q;
    assign dsp_ce       = dsp_ce_q;
    assign dsp_rst      = dsp_rst_q;

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        count_d        = count_q;
        drain_d        = drain_q;
        cap_pend_d     = 1'b0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        dsp_a_d        = '0;
        dsp_b_d        = '0;
        dsp_ce_d       = 1'b0;
        dsp_rst_d      = 1'b0;

        // P settles on the edge that ends CAPTURE, so it is sampled one edge later.
        if (cap_pend_q) begin
            result_d       = dsp_p;
            result_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = len;
                    count_d   = '0;
                    dsp_rst_d = 1'b1;
                    state_d   = CLR;
                end
            end
            CLR: begin
                drain_d = '0;
                state_d = (len_q != '0) ? FEED : DRAIN;
            end
            FEED: begin
                if (hs) begin
                    dsp_a_d  = in_a;
                    dsp_b_d  = in_b;
                    dsp_ce_d = 1'b1;
                    count_d  = count_q + LEN_W'(1);
                    if (count_q + LEN_W'(1) == len_q) begin
                        drain_d = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Zero operands push the last product through M and P without changing the sum.
                dsp_ce_d = 1'b1;
                if (drain_q == DRN_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            CAPTURE: begin
                cap_pend_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d       = (state_d != IDLE);
        dsp_opmode_d = (state_d != IDLE) ? OPM_MAC : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q        <= IDLE;
            len_q          <= '0;
            count_q        <= '0;
            drain_q        <= '0;
            cap_pend_q     <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            dsp_a_q        <= '0;
            dsp_b_q        <= '0;
            dsp_opmode_q   <= 8'h00;
            dsp_ce_q       <= 1'b0;
            dsp_rst_q      <= 1'b1;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            count_q        <= count_d;
            drain_q        <= drain_d;
            cap_pend_q     <= cap_pend_d;
            busy_q         <= busy_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            dsp_a_q        <= dsp_a_d;
            dsp_b_q        <= dsp_b_d;
            dsp_opmode_q   <= dsp_opmode_d;
            dsp_ce_q       <= dsp_ce_d;
            dsp_rst_q      <= dsp_rst_d;
        end
    end

endmodule
